// File: rtl/usb_fs_rx.sv
// usb_fs_rx: USB full-speed packet receiver with oversampled clock recovery,
// NRZI decode, bit unstuffing, byte assembly and PID/CRC/length/EOP checks.
module usb_fs_rx #(
   parameter int OVERSAMPLE   = 4,
   parameter int MAX_BYTES    = 1027,
   parameter int RESET_CYCLES = 120,
   parameter bit CHECK_CRC    = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        dp,
   input  logic        dn,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic        packet_start,
   output logic        packet_end,
   output logic [3:0]  pid,
   output logic [10:0] byte_count,
   output logic [2:0]  error_code,
   output logic        packet_ok,
   output logic        bus_reset
);
   localparam int PW = $clog2(OVERSAMPLE);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam logic [PW-1:0] MID  = PW'(OVERSAMPLE / 2 - 1);
   localparam logic [PW-1:0] PMAX = PW'(OVERSAMPLE - 1);
   localparam logic [RW-1:0] RMAX = RW'(RESET_CYCLES);
   localparam logic [10:0]   MAXB = 11'(MAX_BYTES);
   localparam logic [1:0]    LJ   = 2'b10;
   localparam logic [1:0]    LK   = 2'b01;

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]    last_q, last_d, prev_q, prev_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [2:0]    ones_q, ones_d, bits_q, bits_d;
   logic [7:0]    sr_q, sr_d;
   logic [10:0]   cnt_q, cnt_d;
   logic [3:0]    alt_q, alt_d, nsamp_q, nsamp_d;
   logic [4:0]    crc5_q, crc5_d;
   logic [15:0]   crc16_q, crc16_d;
   logic          seen_q, seen_d;
   logic [7:0]    byte_data_q, byte_data_d;
   logic          byte_valid_q, byte_valid_d;
   logic          packet_start_q, packet_start_d;
   logic          packet_end_q, packet_end_d;
   logic [3:0]    pid_q, pid_d;
   logic [10:0]   byte_count_q, byte_count_d;
   logic [2:0]    error_code_q, error_code_d;
   logic          packet_ok_q, packet_ok_d;
   logic          bus_reset_q, bus_reset_d;

   logic [1:0]  line;
   logic        chg, stb, se0, se1, is_j, is_k, din;
   logic        fail, len_bad, crc_bad;
   logic [2:0]  code, eop_code;
   logic [4:0]  c5;
   logic [15:0] c16;
   logic [7:0]  byte_nxt;

   assign line = sync2_q;
   assign se0  = line == 2'b00;
   assign se1  = line == 2'b11;
   assign is_j = line == LJ;
   assign is_k = line == LK;
   // Only a clean J<->K edge realigns the bit clock
   assign chg  = (line[1] ^ line[0]) && (line == ~last_q);
   assign stb  = phase_q == MID;
   assign din  = line == prev_q;
   assign c5   = {crc5_q[3:0], 1'b0}
               ^ ((din ^ crc5_q[4]) ? 5'b00101 : 5'b0);
   assign c16  = {crc16_q[14:0], 1'b0}
               ^ ((din ^ crc16_q[15]) ? 16'h8005 : 16'h0);
   assign byte_nxt = {din, sr_q[7:1]};

   always_comb begin
      len_bad = 1'b0;
      crc_bad = 1'b0;
      unique case (pid_q[1:0])
         2'b01: begin
            len_bad = cnt_q != 11'd3;
            crc_bad = crc5_q != 5'b01100;
         end
         2'b10: len_bad = cnt_q != 11'd1;
         2'b11: begin
            len_bad = cnt_q < 11'd3;
            crc_bad = crc16_q != 16'h800D;
         end
         default: ;
      endcase
      if (bits_q != 3'd0)                   eop_code = 3'd3;
      else if (cnt_q == 11'd0 || len_bad)   eop_code = 3'd5;
      else if (CHECK_CRC && crc_bad)        eop_code = 3'd4;
      else                                  eop_code = 3'd0;
   end

   always_comb begin
      state_d        = state_q;
      sync1_d        = {dp, dn};
      sync2_d        = sync1_q;
      last_d         = line;
      prev_d         = prev_q;
      ones_d         = ones_q;
      bits_d         = bits_q;
      sr_d           = sr_q;
      cnt_d          = cnt_q;
      alt_d          = alt_q;
      nsamp_d        = nsamp_q;
      crc5_d         = crc5_q;
      crc16_d        = crc16_q;
      seen_d         = seen_q;
      byte_data_d    = byte_data_q;
      byte_valid_d   = 1'b0;
      packet_start_d = 1'b0;
      packet_end_d   = 1'b0;
      pid_d          = pid_q;
      byte_count_d   = byte_count_q;
      error_code_d   = error_code_q;
      packet_ok_d    = packet_ok_q;
      fail           = 1'b0;
      code           = 3'd0;
      if (chg)               phase_d = '0;
      else if (phase_q == PMAX) phase_d = '0;
      else                   phase_d = phase_q + PW'(1);
      if (!se0)                rcnt_d = '0;
      else if (rcnt_q == RMAX) rcnt_d = rcnt_q;
      else                     rcnt_d = rcnt_q + RW'(1);
      bus_reset_d = rcnt_d == RMAX;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (chg && is_k) begin
               state_d = SYNC;
               prev_d  = LJ;
               alt_d   = 4'd0;
               nsamp_d = 4'd0;
            end
            SYNC: if (stb) begin
               if (se0 || se1) begin
                  state_d = IDLE;
               end else begin
                  prev_d  = line;
                  nsamp_d = nsamp_q + 4'd1;
                  if (line != prev_q) alt_d = alt_q + 4'd1;
                  else                alt_d = 4'd0;
                  if (line == prev_q && is_k && alt_q >= 4'd3) begin
                     state_d = DATA;
                     ones_d  = 3'd1;
                     bits_d  = 3'd0;
                     cnt_d   = 11'd0;
                     crc5_d  = 5'h1F;
                     crc16_d = 16'hFFFF;
                  end else if (nsamp_q == 4'd11) begin
                     state_d = IDLE;
                  end
               end
            end
            DATA: if (stb) begin
               if (se0) begin
                  state_d = EOP;
               end else if (se1) begin
                  fail = 1'b1;
                  code = 3'd6;
               end else begin
                  prev_d = line;
                  if (ones_q == 3'd6) begin
                     ones_d = 3'd0;
                     if (din) begin
                        fail = 1'b1;
                        code = 3'd2;
                     end
                  end else begin
                     ones_d = din ? ones_q + 3'd1 : 3'd0;
                     sr_d   = byte_nxt;
                     bits_d = bits_q + 3'd1;
                     if (cnt_q != 11'd0) begin
                        crc5_d  = c5;
                        crc16_d = c16;
                     end
                     if (bits_q == 3'd7) begin
                        cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                        if (cnt_q >= MAXB) begin
                           fail = 1'b1;
                           code = 3'd5;
                        end else begin
                           byte_valid_d = 1'b1;
                           byte_data_d  = byte_nxt;
                           if (cnt_q == 11'd0) begin
                              packet_start_d = 1'b1;
                              pid_d          = byte_nxt[3:0];
                              if (byte_nxt[7:4] != ~byte_nxt[3:0]) begin
                                 fail = 1'b1;
                                 code = 3'd1;
                              end
                           end
                        end
                     end
                  end
               end
            end
            EOP: if (stb) begin
               if (se1) begin
                  fail = 1'b1;
                  code = 3'd6;
               end else if (!se0) begin
                  state_d      = IDLE;
                  packet_end_d = 1'b1;
                  error_code_d = eop_code;
                  packet_ok_d  = eop_code == 3'd0;
                  byte_count_d = cnt_q;
               end
            end
            ERR: if (stb) begin
               if (se0)                seen_d  = 1'b1;
               else if (is_j && seen_q) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (fail) begin
            state_d      = ERR;
            seen_d       = 1'b0;
            packet_end_d = 1'b1;
            error_code_d = code;
            packet_ok_d  = 1'b0;
            byte_count_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         sync1_q        <= '0;
         sync2_q        <= '0;
         last_q         <= '0;
         prev_q         <= '0;
         phase_q        <= '0;
         rcnt_q         <= '0;
         ones_q         <= '0;
         bits_q         <= '0;
         sr_q           <= '0;
         cnt_q          <= '0;
         alt_q          <= '0;
         nsamp_q        <= '0;
         crc5_q         <= '0;
         crc16_q        <= '0;
         seen_q         <= 1'b0;
         byte_data_q    <= '0;
         byte_valid_q   <= 1'b0;
         packet_start_q <= 1'b0;
         packet_end_q   <= 1'b0;
         pid_q          <= '0;
         byte_count_q   <= '0;
         error_code_q   <= '0;
         packet_ok_q    <= 1'b0;
         bus_reset_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         last_q         <= last_d;
         prev_q         <= prev_d;
         phase_q        <= phase_d;
         rcnt_q         <= rcnt_d;
         ones_q         <= ones_d;
         bits_q         <= bits_d;
         sr_q           <= sr_d;
         cnt_q          <= cnt_d;
         alt_q          <= alt_d;
         nsamp_q        <= nsamp_d;
         crc5_q         <= crc5_d;
         crc16_q        <= crc16_d;
         seen_q         <= seen_d;
         byte_data_q    <= byte_data_d;
         byte_valid_q   <= byte_valid_d;
         packet_start_q <= packet_start_d;
         packet_end_q   <= packet_end_d;
         pid_q          <= pid_d;
         byte_count_q   <= byte_count_d;
         error_code_q   <= error_code_d;
         packet_ok_q    <= packet_ok_d;
         bus_reset_q    <= bus_reset_d;
      end
   end

   assign byte_data    = byte_data_q;
   assign byte_valid   = byte_valid_q;
   assign packet_start = packet_start_q;
   assign packet_end   = packet_end_q;
   assign pid          = pid_q;
   assign byte_count   = byte_count_q;
   assign error_code   = error_code_q;
   assign packet_ok    = packet_ok_q;
   assign bus_reset    = bus_reset_q;
endmodule
